// File: rtl/aap_exec_regfile.sv
// AAP 16-bit execute stage: 64 x 16 register file plus single-cycle ALU with write-back.
// Optional carry flag and ADDC/SUBC (ops 16/17) enabled by defining AAP_CARRY_EN.
module aap_exec_regfile #(
  parameter int NUM_REGS = 64,
  parameter int DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [5:0]        operationnumber,
  input  logic [2:0]        destination,
  input  logic [2:0]        source_1,
  input  logic [2:0]        source_2,
  input  logic [2:0]        unsigned_1,
  input  logic [5:0]        unsigned_2,
  input  logic [8:0]        unsigned_3,
  input  logic [5:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              illegal_op,
  output logic              carry
);

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_ASR   = 6'd6,
    OP_LSL   = 6'd7,
    OP_LSR   = 6'd8,
    OP_MOV   = 6'd9,
    OP_ADDI  = 6'd10,
    OP_SUBI  = 6'd11,
    OP_ASRI  = 6'd12,
    OP_LSLI  = 6'd13,
    OP_LSRI  = 6'd14,
    OP_MOVI  = 6'd15,
    OP_ADDC  = 6'd16,
    OP_SUBC  = 6'd17,
    OP_ADDI6 = 6'd18
  } op_e;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              illegal_op_q, illegal_op_d;

  logic [5:0]        src1_idx, src2_idx, dst_idx;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] imm1, imm2, imm3;
  op_e               op;

  logic              op_legal;
  logic              alu_write;
  logic [DATA_W-1:0] alu_val;

  // Shared adder/subtractor; bit DATA_W is the carry-out or the borrow.
  logic              add_sub;
  logic [DATA_W-1:0] add_rhs;
  logic              add_cin;
  logic              carry_upd;
  logic [DATA_W:0]   sum;

`ifdef AAP_CARRY_EN
  logic carry_q, carry_d;
  logic carry_in;
  assign carry_in = carry_q;
`else
  logic carry_in;
  logic unused_carry;
  assign carry_in     = 1'b0;
  assign unused_carry = ^{carry_upd, sum[DATA_W]};
`endif

  assign src1_idx = {3'b000, source_1};
  assign src2_idx = {3'b000, source_2};
  assign dst_idx  = {3'b000, destination};
  assign op_a     = regs_q[src1_idx];
  assign op_b     = regs_q[src2_idx];
  assign imm1     = {{(DATA_W-3){1'b0}}, unsigned_1};
  assign imm2     = {{(DATA_W-6){1'b0}}, unsigned_2};
  assign imm3     = {{(DATA_W-9){1'b0}}, unsigned_3};
  assign op       = op_e'(operationnumber);

  always_comb begin
    op_legal  = 1'b1;
    alu_write = 1'b1;
    alu_val   = '0;
    add_sub   = 1'b0;
    add_rhs   = op_b;
    add_cin   = 1'b0;
    carry_upd = 1'b0;
    case (op)
      OP_NOP:   alu_write = 1'b0;
      OP_ADD:   carry_upd = 1'b1;
      OP_SUB:   begin add_sub = 1'b1; carry_upd = 1'b1; end
      OP_ADDI:  begin add_rhs = imm1; carry_upd = 1'b1; end
      OP_SUBI:  begin add_sub = 1'b1; add_rhs = imm1; carry_upd = 1'b1; end
      OP_ADDI6: begin add_rhs = imm2; carry_upd = 1'b1; end
`ifdef AAP_CARRY_EN
      OP_ADDC:  begin add_cin = carry_in; carry_upd = 1'b1; end
      OP_SUBC:  begin add_sub = 1'b1; add_cin = carry_in; carry_upd = 1'b1; end
`endif
      OP_AND, OP_OR, OP_XOR, OP_ASR, OP_LSL, OP_LSR,
      OP_MOV, OP_ASRI, OP_LSLI, OP_LSRI, OP_MOVI: ;
      default: begin
        op_legal  = 1'b0;
        alu_write = 1'b0;
      end
    endcase

    if (add_sub)
      sum = {1'b0, op_a} - {1'b0, add_rhs} - {{DATA_W{1'b0}}, add_cin};
    else
      sum = {1'b0, op_a} + {1'b0, add_rhs} + {{DATA_W{1'b0}}, add_cin};

    case (op)
      OP_AND:  alu_val = op_a & op_b;
      OP_OR:   alu_val = op_a | op_b;
      OP_XOR:  alu_val = op_a ^ op_b;
      OP_ASR:  alu_val = DATA_W'($signed(op_a) >>> op_b[3:0]);
      OP_LSL:  alu_val = op_a << op_b[3:0];
      OP_LSR:  alu_val = op_a >> op_b[3:0];
      OP_MOV:  alu_val = op_a;
      OP_ASRI: alu_val = DATA_W'($signed(op_a) >>> unsigned_1);
      OP_LSLI: alu_val = op_a << unsigned_1;
      OP_LSRI: alu_val = op_a >> unsigned_1;
      OP_MOVI: alu_val = imm3;
      default: alu_val = sum[DATA_W-1:0];
    endcase
  end

  // Write-back and strobes; only r0-r7 are addressable as destinations.
  always_comb begin
    regs_d         = regs_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    illegal_op_d   = 1'b0;
`ifdef AAP_CARRY_EN
    carry_d        = carry_q;
`endif
    if (op_valid) begin
      result_valid_d = op_legal;
      illegal_op_d   = ~op_legal;
      if (alu_write) begin
        regs_d[dst_idx] = alu_val;
        result_d        = alu_val;
      end
`ifdef AAP_CARRY_EN
      if (carry_upd)
        carry_d = sum[DATA_W];
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q         <= '{default: '0};
      result_q       <= '0;
      result_valid_q <= 1'b0;
      illegal_op_q   <= 1'b0;
`ifdef AAP_CARRY_EN
      carry_q        <= 1'b0;
`endif
    end else begin
      regs_q         <= regs_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      illegal_op_q   <= illegal_op_d;
`ifdef AAP_CARRY_EN
      carry_q        <= carry_d;
`endif
    end
  end

  assign dbg_data     = regs_q[dbg_addr];
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign illegal_op   = illegal_op_q;
`ifdef AAP_CARRY_EN
  assign carry        = carry_q;
`else
  assign carry        = 1'b0;
`endif

endmodule

// File: tb/tb_aap_exec_regfile.sv
// Self-checking bench for aap_exec_regfile: vector table with scoreboard queue,
// plus reset sweep and mid-operation reset sequences.
module tb_aap_exec_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  operationnumber;
  logic [2:0]  destination, source_1, source_2, unsigned_1;
  logic [5:0]  unsigned_2;
  logic [8:0]  unsigned_3;
  logic [5:0]  dbg_addr;
  logic [15:0] dbg_data, result;
  logic        result_valid, illegal_op, carry;

  always #5 clock = ~clock;

  aap_exec_regfile dut (
    .clock           (clock),
    .reset           (reset),
    .op_valid        (op_valid),
    .operationnumber (operationnumber),
    .destination     (destination),
    .source_1        (source_1),
    .source_2        (source_2),
    .unsigned_1      (unsigned_1),
    .unsigned_2      (unsigned_2),
    .unsigned_3      (unsigned_3),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .result          (result),
    .result_valid    (result_valid),
    .illegal_op      (illegal_op),
    .carry           (carry)
  );

`ifdef AAP_CARRY_EN
  localparam logic CY      = 1'b1;
  localparam logic MAIN_CK = 1'b0;
`else
  localparam logic CY      = 1'b0;
  localparam logic MAIN_CK = 1'b1;
`endif

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic [2:0]  dst, s1, s2, u1;
    logic [5:0]  u2;
    logic [8:0]  u3;
    logic [5:0]  chk_addr;
    logic [15:0] exp_reg;
    logic [15:0] exp_res;
    logic        exp_rv, exp_ill, exp_carry, chk_carry;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(logic v, logic [5:0] op, logic [2:0] dst, logic [2:0] s1,
                              logic [2:0] s2, logic [2:0] u1, logic [5:0] u2, logic [8:0] u3,
                              logic [5:0] ca, logic [15:0] er, logic [15:0] eres,
                              logic rv, logic ill, logic cy, logic ck);
    vec_t t;
    t.valid = v; t.op = op; t.dst = dst; t.s1 = s1; t.s2 = s2;
    t.u1 = u1; t.u2 = u2; t.u3 = u3; t.chk_addr = ca; t.exp_reg = er;
    t.exp_res = eres; t.exp_rv = rv; t.exp_ill = ill; t.exp_carry = cy; t.chk_carry = ck;
    return t;
  endfunction

  task automatic check_val(string name, logic [15:0] act, logic [15:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(int idx);
    vec_t e;
    if (sb.size() == 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL v%0d scoreboard: got empty queue expected entry", idx);
      return;
    end
    e = sb.pop_front();
    check_val($sformatf("v%0d result", idx), result, e.exp_res);
    check_val($sformatf("v%0d result_valid", idx), {15'b0, result_valid}, {15'b0, e.exp_rv});
    check_val($sformatf("v%0d illegal_op", idx), {15'b0, illegal_op}, {15'b0, e.exp_ill});
    check_val($sformatf("v%0d reg[%0d]", idx, e.chk_addr), dbg_data, e.exp_reg);
    if (e.chk_carry)
      check_val($sformatf("v%0d carry", idx), {15'b0, carry}, {15'b0, e.exp_carry});
  endtask

  task automatic apply_stimulus(vec_t v, int idx);
    @(negedge clock);
    op_valid        = v.valid;
    operationnumber = v.op;
    destination     = v.dst;
    source_1        = v.s1;
    source_2        = v.s2;
    unsigned_1      = v.u1;
    unsigned_2      = v.u2;
    unsigned_3      = v.u3;
    dbg_addr        = v.chk_addr;
    sb.push_back(v);
    @(posedge clock);
    #1;
    check_output(idx);
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; operationnumber = '0; destination = '0; source_1 = '0;
    source_2 = '0; unsigned_1 = '0; unsigned_2 = '0; unsigned_3 = '0; dbg_addr = '0;
  endtask

  task automatic reset_sweep(string tag);
    for (int a = 0; a < 64; a++) begin
      dbg_addr = 6'(a);
      #1;
      check_val($sformatf("%s dbg[%0d]", tag, a), dbg_data, 16'h0000);
    end
    check_val({tag, " result"}, result, 16'h0000);
    check_val({tag, " result_valid"}, {15'b0, result_valid}, 16'h0000);
    check_val({tag, " illegal_op"}, {15'b0, illegal_op}, 16'h0000);
    check_val({tag, " carry"}, {15'b0, carry}, 16'h0000);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    reset_sweep("reset");

    // Dependent sequence: each vector relies on registers written by earlier ones.
    vecs.push_back(mk(1, 15, 1, 0, 0, 0, 0, 9'h002, 1, 16'h0002, 16'h0002, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 15, 2, 0, 0, 0, 0, 9'h003, 2, 16'h0003, 16'h0003, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  1, 3, 1, 2, 0, 0, 9'h000, 3, 16'h0005, 16'h0005, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 15, 1, 0, 0, 0, 0, 9'h1FF, 1, 16'h01FF, 16'h01FF, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 13, 1, 1, 0, 7, 0, 9'h000, 1, 16'hFF80, 16'hFF80, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 10, 1, 1, 0, 7, 0, 9'h000, 1, 16'hFF87, 16'hFF87, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  2, 4, 2, 1, 0, 0, 9'h000, 4, 16'h007C, 16'h007C, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 63, 4, 1, 1, 0, 0, 9'h000, 4, 16'h007C, 16'h007C, 0, 1, 0, MAIN_CK));
    vecs.push_back(mk(0,  1, 4, 1, 1, 0, 0, 9'h000, 4, 16'h007C, 16'h007C, 0, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  0, 4, 1, 1, 0, 0, 9'h000, 1, 16'hFF87, 16'h007C, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 15, 5, 0, 0, 0, 0, 9'h100, 5, 16'h0100, 16'h0100, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 13, 5, 5, 0, 7, 0, 9'h000, 5, 16'h8000, 16'h8000, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 15, 6, 0, 0, 0, 0, 9'h00F, 6, 16'h000F, 16'h000F, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  6, 7, 5, 6, 0, 0, 9'h000, 7, 16'hFFFF, 16'hFFFF, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  8, 7, 5, 6, 0, 0, 9'h000, 7, 16'h0001, 16'h0001, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  7, 7, 6, 6, 0, 0, 9'h000, 7, 16'h8000, 16'h8000, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  3, 0, 1, 2, 0, 0, 9'h000, 0, 16'h0003, 16'h0003, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  4, 0, 1, 2, 0, 0, 9'h000, 0, 16'hFF87, 16'hFF87, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  5, 0, 1, 6, 0, 0, 9'h000, 0, 16'hFF88, 16'hFF88, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1,  9, 0, 3, 0, 0, 0, 9'h000, 0, 16'h0005, 16'h0005, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 11, 0, 3, 0, 7, 0, 9'h000, 0, 16'hFFFE, 16'hFFFE, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 12, 0, 5, 0, 3, 0, 9'h000, 0, 16'hF000, 16'hF000, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 14, 0, 5, 0, 3, 0, 9'h000, 0, 16'h1000, 16'h1000, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 18, 0, 3, 0, 0, 63, 9'h000, 0, 16'h0044, 16'h0044, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 15, 7, 0, 0, 0, 0, 9'h0AA, 15, 16'h0000, 16'h00AA, 1, 0, 0, MAIN_CK));
    vecs.push_back(mk(1, 19, 7, 0, 0, 0, 0, 9'h155, 7, 16'h00AA, 16'h00AA, 0, 1, 0, MAIN_CK));

    foreach (vecs[i]) apply_stimulus(vecs[i], i);

    // Reset asserted while a legal write is pending must win over the write.
    @(negedge clock);
    op_valid = 1'b1; operationnumber = 6'd15; destination = 3'd3; unsigned_3 = 9'h1AB;
    dbg_addr = 6'd3;
    #2 reset = 1'b0;
    #1;
    check_val("midreset async reg3", dbg_data, 16'h0000);
    check_val("midreset async result", result, 16'h0000);
    @(posedge clock);
    #1;
    check_val("midreset edge reg3", dbg_data, 16'h0000);
    check_val("midreset edge result_valid", {15'b0, result_valid}, 16'h0000);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    reset_sweep("midreset");

    // Carry / wrap sequence from a freshly reset register file.
    vecs.delete();
    vecs.push_back(mk(1, 11, 1, 1, 0, 1, 0, 9'h000, 1, 16'hFFFF, 16'hFFFF, 1, 0, CY, 1));
    vecs.push_back(mk(1, 10, 1, 1, 0, 1, 0, 9'h000, 1, 16'h0000, 16'h0000, 1, 0, CY, 1));
    vecs.push_back(mk(1, 15, 0, 0, 0, 0, 0, 9'h000, 0, 16'h0000, 16'h0000, 1, 0, CY, 1));
`ifdef AAP_CARRY_EN
    vecs.push_back(mk(1, 16, 2, 0, 0, 0, 0, 9'h000, 2, 16'h0001, 16'h0001, 1, 0, 0, 1));
    vecs.push_back(mk(1, 17, 2, 0, 2, 0, 0, 9'h000, 2, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1));
    vecs.push_back(mk(1, 17, 3, 2, 2, 0, 0, 9'h000, 3, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1));
    vecs.push_back(mk(1,  3, 4, 2, 2, 0, 0, 9'h000, 4, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1));
`else
    vecs.push_back(mk(1, 16, 2, 0, 0, 0, 0, 9'h000, 2, 16'h0000, 16'h0000, 0, 1, 0, 1));
    vecs.push_back(mk(1, 17, 2, 0, 0, 0, 0, 9'h000, 2, 16'h0000, 16'h0000, 0, 1, 0, 1));
`endif
    foreach (vecs[i]) apply_stimulus(vecs[i], 100 + i);

    if (sb.size() != 0) begin
      applied++;
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/aap_exec_regfile.md
Name: aap_exec_regfile

Overview:
- Single-cycle execute stage for the 16-bit AAP pipeline.
- Combines a 64 x 16-bit register file with an ALU driven by the already-decoded 16-bit instruction fields: operation number, destination, two sources and three unsigned immediates.
- Sits directly after the 16-bit decoder.
- Reads operands combinationally and writes the ALU result back to the register file on the next rising clock edge.

Parameters:
- NUM_REGS, 64, register file depth; addresses are 6 bits.
- DATA_W, 16, register and datapath width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  decoded instruction present this cycle.
- operationnumber  in  6  decoded operation code; encoding is listed under Behaviour.
- destination  in  3  destination register index, zero-extended to 6 bits.
- source_1  in  3  first source register index, zero-extended.
- source_2  in  3  second source register index, zero-extended.
- unsigned_1  in  3  3-bit immediate.
- unsigned_2  in  6  6-bit immediate.
- unsigned_3  in  9  9-bit immediate.
- dbg_addr  in  6  debug read address, covering any of the 64 registers.
- dbg_data  out  16  combinational contents of the register at dbg_addr.
- result  out  16  registered ALU result of the last executed operation.
- result_valid  out  1  one-cycle pulse when result and the register write are updated.
- illegal_op  out  1  one-cycle pulse for an unrecognised operationnumber while op_valid is high.
- carry  out  1  carry flag; driven 0 when AAP_CARRY_EN is not defined.

Behaviour:
- Reset (reset=0, asynchronous):
  - all 64 registers are cleared to 0;
  - result=0, result_valid=0, illegal_op=0, carry=0.
- Operand reads are combinational: A = reg[{3'b0,source_1}], B = reg[{3'b0,source_2}].
- Operation encoding (all arithmetic is modulo 2^16; immediates are zero-extended):
  - 0 NOP: no write; result_valid pulses.
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 XOR: A^B.
  - 6 ASR: A>>>B[3:0].
  - 7 LSL: A<<B[3:0].
  - 8 LSR: A>>B[3:0].
  - 9 MOV: A.
  - 10 ADDI: A+unsigned_1.
  - 11 SUBI: A-unsigned_1.
  - 12 ASRI, 13 LSLI, 14 LSRI: shift A by unsigned_1 (0-7).
  - 15 MOVI: unsigned_3 zero-extended to 16 bits.
  - 18 ADDI6: A+unsigned_2.
  - 16 and 17 are reserved for the optional feature.
- Illegal operations:
  - Any other code with op_valid=1 is illegal: no register write, result is unchanged, result_valid=0, illegal_op=1 for one cycle.
- Legal, non-NOP operation with op_valid=1:
  - on the rising edge, reg[{3'b0,destination}] and result are both loaded with the ALU value;
  - result_valid=1 for that cycle.
- Latency and hazards:
  - latency is 1 cycle;
  - back-to-back dependent instructions work without stalls, because the write completes at the edge before the next combinational read.
- With op_valid=0: no write, result holds its value, and both strobes are 0.
- Registers 8-63 are reachable only through the debug port and are never written by this block.
- Reset asserted mid-operation overrides any pending write.

Optional Feature:
- Macro AAP_CARRY_EN.
- When defined:
  - op 16 ADDC: A+B+carry;
  - op 17 SUBC: A-B-carry;
  - the carry flag is updated by ADD, SUB, ADDI, SUBI, ADDI6, ADDC and SUBC (carry-out of the addition / borrow of the subtraction), and is held by all other operations.
- When undefined:
  - ops 16 and 17 are illegal;
  - carry is tied to 0.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then sweep dbg_addr 0-63 → every dbg_data=0; result=0, result_valid=0.
- MOVI then ADD: MOVI r1,2 and MOVI r2,3, then ADD r3=r1+r2 → dbg_data(3)=5 one cycle after the ADD; result_valid pulses each cycle.
- Wrap and SUB: MOVI r1,0x1FF, then LSLI r1,7 → 0xFF80; ADDI r1,7 → 0xFF87; SUB r4=r2(3)-r1 → 0x007C.
- Illegal op: operationnumber=63 with op_valid=1 → illegal_op=1 for one cycle, no register change, result unchanged.
- Shifts: r5=0x8000; ASR by r6=15 → 0xFFFF; LSR by r6 → 0x0001.
- AAP_CARRY_EN: r1=0xFFFF; ADDI r1,1 → 0x0000 with carry=1; ADDC r2=r0+r0 → 1 and carry=0. Without the macro, op 16 → illegal_op=1.
